rx_meas_sequencer: RTL and testbench

Controls the receive datapath (DC blocker → mixer → CIC decimator → power → dB). On a start request it flushes the filter chain and enables it. It discards the dB results produced while the filters settle, then averages and peak-holds a fixed number of dB results. The finished measurement is presented on a valid/ready output and feeds the detection/telemetry logic.

---
 rtl/rx_ctrl_pkg.sv | 23 ++
 rtl/rx_meas_accum.sv | 80 ++++++++
 rtl/rx_meas_sequencer.sv | 154 +++++++++++++++
 tb/tb_rx_meas_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared types and width helpers for the receive measurement sequencer.
// Imported by the sequencer top and its accumulator.
package rx_ctrl_pkg;

    localparam int DB_DW = 16;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        SETTLE,
        ACCUM,
        HOLD
    } seq_state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int sum_width(input int avg_log2);
        return DB_DW + avg_log2;
    endfunction

endpackage

// File: rtl/rx_meas_accum.sv
// Window accumulator: running sum, peak and sample count over 2**AVG_LOG2
// dB results, registering the average and peak when the window completes.
module rx_meas_accum
    import rx_ctrl_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             strobe_i,
    input  logic [DB_DW-1:0] data_i,
    output logic             done_o,
    output logic [DB_DW-1:0] avg_o,
    output logic [DB_DW-1:0] peak_o
);

    localparam int SW = sum_width(AVG_LOG2);
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

    logic [SW-1:0]    sum_q, sum_d, sum_nx;
    logic [DB_DW-1:0] run_peak_q, run_peak_d, peak_nx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DB_DW-1:0] avg_q, avg_d;
    logic [DB_DW-1:0] peak_out_q, peak_out_d;
    logic             done;

    always_comb begin
        sum_nx  = sum_q + SW'(data_i);
        // First sample of a window seeds the peak regardless of prior value.
        peak_nx = (cnt_q == '0 || data_i > run_peak_q) ? data_i : run_peak_q;
        done    = strobe_i && !clear_i && (cnt_q == LAST);

        sum_d      = sum_q;
        run_peak_d = run_peak_q;
        cnt_d      = cnt_q;
        avg_d      = avg_q;
        peak_out_d = peak_out_q;

        if (clear_i) begin
            sum_d      = '0;
            run_peak_d = '0;
            cnt_d      = '0;
        end else if (strobe_i) begin
            if (done) begin
                avg_d      = sum_nx[AVG_LOG2 +: DB_DW];
                peak_out_d = peak_nx;
                sum_d      = '0;
                run_peak_d = '0;
                cnt_d      = '0;
            end else begin
                sum_d      = sum_nx;
                run_peak_d = peak_nx;
                cnt_d      = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            run_peak_q <= '0;
            cnt_q      <= '0;
            avg_q      <= '0;
            peak_out_q <= '0;
        end else begin
            sum_q      <= sum_d;
            run_peak_q <= run_peak_d;
            cnt_q      <= cnt_d;
            avg_q      <= avg_d;
            peak_out_q <= peak_out_d;
        end
    end

    assign done_o = done;
    assign avg_o  = avg_q;
    assign peak_o = peak_out_q;

endmodule

// File: rtl/rx_meas_sequencer.sv
// Receive measurement sequencer: flush, settle, accumulate and hold a dB
// measurement, with watchdog timeout and abort.
module rx_meas_sequencer
    import rx_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES   = 32,
    parameter int SETTLE_COUNT   = 8,
    parameter int AVG_LOG2       = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             continuous_i,
    input  logic             abort_i,
    output logic             dp_rst_o,
    output logic             dp_en_o,
    input  logic [DB_DW-1:0] db_i,
    input  logic             db_valid_i,
    output logic [DB_DW-1:0] meas_avg_o,
    output logic [DB_DW-1:0] meas_peak_o,
    output logic             meas_valid_o,
    input  logic             meas_ready_i,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int CNT_W = cnt_width(255);
    localparam int WD_W  = cnt_width((1 << 20) - 1);

    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_COUNT - 1);
    localparam logic [WD_W-1:0]  WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);

    localparam seq_state_t POST_FLUSH = (SETTLE_COUNT == 0) ? ACCUM : SETTLE;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 255 ||
        SETTLE_COUNT < 0 || SETTLE_COUNT > 255 ||
        AVG_LOG2 < 0 || AVG_LOG2 > 8 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << 20) - 1) begin : g_param_err
        $error("rx_meas_sequencer: parameter out of range");
    end

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;

    logic acc_clear;
    logic acc_strobe;
    logic acc_done;

    assign acc_clear  = (state_q != ACCUM);
    assign acc_strobe = (state_q == ACCUM) && db_valid_i && !abort_i;

    rx_meas_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (acc_clear),
        .strobe_i (acc_strobe),
        .data_i   (db_i),
        .done_o   (acc_done),
        .avg_o    (meas_avg_o),
        .peak_o   (meas_peak_o)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;

        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            wd_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d   = FLUSH;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                    end
                end
                FLUSH: begin
                    if (cnt_q == FLUSH_LAST) begin
                        state_d = POST_FLUSH;
                        cnt_d   = '0;
                        wd_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SETTLE, ACCUM: begin
                    if (db_valid_i) begin
                        wd_d = '0;
                        if (state_q == SETTLE) begin
                            if (cnt_q == SETTLE_LAST) begin
                                state_d = ACCUM;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end else if (acc_done) begin
                            state_d = HOLD;
                        end
                    end else if (wd_q == WD_LAST) begin
                        // Stalled datapath: drop the window and flag it.
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        wd_d      = '0;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                HOLD: begin
                    if (meas_ready_i) begin
                        state_d = continuous_i ? POST_FLUSH : IDLE;
                        cnt_d   = '0;
                        wd_d    = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign dp_rst_o     = (state_q == IDLE) || (state_q == FLUSH);
    assign dp_en_o      = (state_q == SETTLE) || (state_q == ACCUM);
    assign meas_valid_o = (state_q == HOLD);
    assign busy_o       = (state_q != IDLE);
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_rx_meas_sequencer.sv
// Self-checking bench for rx_meas_sequencer: reference model plus
// directed scenarios with literal expectations.
module tb_rx_meas_sequencer;

    localparam int FL = 4;
    localparam int ST = 3;
    localparam int AL = 2;
    localparam int TO = 50;

    localparam int P_IDLE   = 0;
    localparam int P_FLUSH  = 1;
    localparam int P_SETTLE = 2;
    localparam int P_ACCUM  = 3;
    localparam int P_HOLD   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        continuous_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        db_valid_i = 1'b0;
    logic        meas_ready_i = 1'b0;
    logic [15:0] db_i = '0;
    logic        dp_rst_o, dp_en_o, meas_valid_o, busy_o, timeout_o;
    logic [15:0] meas_avg_o, meas_peak_o;

    rx_meas_sequencer #(
        .FLUSH_CYCLES   (FL),
        .SETTLE_COUNT   (ST),
        .AVG_LOG2       (AL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .continuous_i (continuous_i),
        .abort_i      (abort_i),
        .dp_rst_o     (dp_rst_o),
        .dp_en_o      (dp_en_o),
        .db_i         (db_i),
        .db_valid_i   (db_valid_i),
        .meas_avg_o   (meas_avg_o),
        .meas_peak_o  (meas_peak_o),
        .meas_valid_o (meas_valid_o),
        .meas_ready_i (meas_ready_i),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus remaining-work counters and a sample window.
    int          ph = P_IDLE;
    int          flush_left = 0;
    int          disc_left = 0;
    int          idle_cnt = 0;
    int          win[$];
    int          m_s = 0;
    int          m_m = 0;
    logic [15:0] e_avg = '0;
    logic [15:0] e_peak = '0;
    logic        e_to = 1'b0;

    task automatic model_idle_tick();
        idle_cnt++;
        if (idle_cnt == TO) begin
            ph = P_IDLE;
            e_to = 1'b1;
            win.delete();
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = P_IDLE;
            e_avg = '0;
            e_peak = '0;
            e_to = 1'b0;
            win.delete();
        end else if (abort_i) begin
            ph = P_IDLE;
            win.delete();
        end else begin
            case (ph)
                P_IDLE: if (start_i) begin
                    ph = P_FLUSH;
                    flush_left = FL;
                    e_to = 1'b0;
                end
                P_FLUSH: begin
                    flush_left--;
                    if (flush_left == 0) begin
                        ph = P_SETTLE;
                        disc_left = ST;
                        idle_cnt = 0;
                    end
                end
                P_SETTLE: if (db_valid_i) begin
                    idle_cnt = 0;
                    disc_left--;
                    if (disc_left == 0) ph = P_ACCUM;
                end else begin
                    model_idle_tick();
                end
                P_ACCUM: if (db_valid_i) begin
                    idle_cnt = 0;
                    win.push_back(int'(db_i));
                    if (win.size() == (1 << AL)) begin
                        m_s = 0;
                        m_m = 0;
                        foreach (win[i]) begin
                            m_s += win[i];
                            if (win[i] > m_m) m_m = win[i];
                        end
                        e_avg = 16'(m_s / (1 << AL));
                        e_peak = 16'(m_m);
                        win.delete();
                        ph = P_HOLD;
                    end
                end else begin
                    model_idle_tick();
                end
                P_HOLD: if (meas_ready_i) begin
                    if (continuous_i) begin
                        ph = P_SETTLE;
                        disc_left = ST;
                        idle_cnt = 0;
                    end else begin
                        ph = P_IDLE;
                    end
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("dp_rst", dp_rst_o, ph <= P_FLUSH);
        chk("dp_en", dp_en_o, ph == P_SETTLE || ph == P_ACCUM);
        chk("busy", busy_o, ph != P_IDLE);
        chk("valid", meas_valid_o, ph == P_HOLD);
        chk("timeout", timeout_o, e_to);
        chk("avg", meas_avg_o, e_avg);
        chk("peak", meas_peak_o, e_peak);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        db_i = 16'(v);
        db_valid_i = 1'b1;
        tick();
        db_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic handshake(input logic cont);
        continuous_i = cont;
        meas_ready_i = 1'b1;
        tick();
        meas_ready_i = 1'b0;
    endtask

    task automatic wait_en();
        int n = 0;
        while (!dp_en_o && n < 40) begin
            tick();
            n++;
        end
        chk("wait_en", dp_en_o, 1);
    endtask

    task automatic discard3(input int v);
        for (int i = 0; i < ST; i++) send(v);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got stuck expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dp_rst", dp_rst_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", meas_valid_o, 0);
        rst_n = 1'b1;
        tick();

        // Basic window; a db pulse on the last flush cycle must be ignored.
        pulse_start();
        n = 0;
        while (dp_rst_o && n < 20) begin
            db_valid_i = (n == FL - 1);
            db_i = 16'd999;
            tick();
            n++;
        end
        db_valid_i = 1'b0;
        chk("flush_len", n, FL);
        send(9); send(9); send(9);
        send(100); send(200); send(300);
        db_i = 16'd400;
        db_valid_i = 1'b1;
        chk("valid_before", meas_valid_o, 0);
        tick();
        db_valid_i = 1'b0;
        chk("valid_lat1", meas_valid_o, 1);
        chk("basic_avg", meas_avg_o, 250);
        chk("basic_peak", meas_peak_o, 400);
        handshake(1'b0);
        chk("basic_idle", busy_o, 0);

        // Truncation and peak, then continuous rearm into a second window.
        pulse_start();
        wait_en();
        discard3(9);
        send(65535); send(65535); send(65535); send(65534);
        chk("trunc_avg", meas_avg_o, 65534);
        chk("trunc_peak", meas_peak_o, 65535);
        handshake(1'b1);
        chk("cont_no_flush", dp_rst_o, 0);
        discard3(50);
        send(1); send(2); send(2); send(2);
        chk("small_avg", meas_avg_o, 1);
        chk("small_peak", meas_peak_o, 2);

        // Backpressure with stray db pulses in HOLD.
        for (int i = 0; i < 20; i++) begin
            db_valid_i = 1'(i % 2);
            db_i = 16'd5000;
            tick();
        end
        db_valid_i = 1'b0;
        chk("bp_valid", meas_valid_o, 1);
        chk("bp_avg", meas_avg_o, 1);
        handshake(1'b1);
        chk("bp_dp_en", dp_en_o, 1);
        discard3(7777);
        send(10); send(20); send(30); send(40);
        chk("cont_avg", meas_avg_o, 25);
        chk("cont_peak", meas_peak_o, 40);
        handshake(1'b0);

        // Watchdog timeout.
        pulse_start();
        wait_en();
        n = 0;
        while (dp_en_o && n < 100) begin
            tick();
            n++;
        end
        chk("to_cycles", n, TO);
        chk("to_flag", timeout_o, 1);
        chk("to_busy", busy_o, 0);
        chk("to_dp_rst", dp_rst_o, 1);
        pulse_start();
        chk("to_clear", timeout_o, 0);

        // Abort mid-window, then a clean restart.
        wait_en();
        discard3(3);
        send(500); send(600);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_to", timeout_o, 0);
        pulse_start();
        wait_en();
        discard3(3);
        send(4); send(8); send(12); send(16);
        chk("restart_avg", meas_avg_o, 10);
        chk("restart_peak", meas_peak_o, 16);
        handshake(1'b0);

        // Abort beats start in IDLE.
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("abort_start_0", busy_o, 0);
        tick();
        chk("abort_start_1", busy_o, 0);

        // Asynchronous reset while holding a result.
        pulse_start();
        wait_en();
        discard3(3);
        send(7); send(7); send(7); send(11);
        chk("hold_avg", meas_avg_o, 8);
        chk("hold_valid", meas_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", meas_valid_o, 0);
        chk("arst_dp_rst", dp_rst_o, 1);
        chk("arst_avg", meas_avg_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_busy", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
